branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 14 +
 rtl/branch_resolver_sat_counter_cnt.sv | 23 ++
 rtl/branch_resolver.sv | 108 ++++++++++
 3 files changed

// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared types and constants for the branch resolver
package branch_resolver_pkg;

  localparam logic [31:0] PC_INC = 32'd4;

  // Prediction metadata that follows an instruction from IF to EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_dest;
  } meta_t;

endpackage

// File: rtl/branch_resolver_sat_counter_cnt.sv
// rtl/branch_resolver_sat_counter_cnt.sv - saturating event counter
module sat_counter_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - carries prediction metadata to EX, detects mispredicts,
// issues predictor feedback and keeps branch/mispredict statistics
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int CHECK_TARGET = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pred_dest,
  input  logic             stall,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             feedback_valid,
  output logic [31:0]      set_pc,
  output logic             set_taken,
  output logic [31:0]      set_destination,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  meta_t       r_id;
  meta_t       r_ex;
  logic        r_fb_valid;
  logic [31:0] r_set_pc;
  logic        r_set_taken;
  logic [31:0] r_set_dest;

  logic w_resolve;
  logic w_br_resolve;
  logic w_dir_wrong;
  logic w_tgt_wrong;
  logic w_alias;
  logic w_mispredict;
  logic w_chk_tgt;

  assign w_chk_tgt    = (CHECK_TARGET != 0);
  assign w_resolve    = r_ex.valid & ~stall;
  assign w_br_resolve = w_resolve & ex_is_branch;
  assign w_dir_wrong  = ex_is_branch & (ex_taken != r_ex.pred_taken);
  assign w_tgt_wrong  = w_chk_tgt & ex_is_branch & ex_taken & r_ex.pred_taken
                        & (ex_target != r_ex.pred_dest);
  // A non-branch the predictor thought was taken: fetch went astray.
  assign w_alias      = ~ex_is_branch & r_ex.pred_taken;
  assign w_mispredict = w_resolve & (w_dir_wrong | w_tgt_wrong | w_alias);

  assign mispredict  = w_mispredict;
  assign redirect_pc = !w_mispredict              ? 32'd0 :
                       (ex_is_branch && ex_taken) ? ex_target :
                                                    r_ex.pc + PC_INC;

  // A mispredict squashes both stages and drops the wrong-path IF sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= '0;
      r_ex <= '0;
    end else if (w_mispredict) begin
      r_id.valid <= 1'b0;
      r_ex.valid <= 1'b0;
    end else if (!stall) begin
      r_id <= {if_valid, if_pc, if_pred_taken, if_pred_dest};
      r_ex <= r_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_valid  <= 1'b0;
      r_set_pc    <= '0;
      r_set_taken <= 1'b0;
      r_set_dest  <= '0;
    end else begin
      r_fb_valid <= w_br_resolve;
      if (w_br_resolve) begin
        r_set_pc    <= r_ex.pc;
        r_set_taken <= ex_taken;
        r_set_dest  <= ex_target;
      end
    end
  end

  assign feedback_valid  = r_fb_valid;
  assign set_pc          = r_set_pc;
  assign set_taken       = r_set_taken;
  assign set_destination = r_set_dest;

  sat_counter_cnt #(.W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_br_resolve),
    .o_count (branch_count)
  );

  sat_counter_cnt #(.W(CNT_W)) u_mispredict_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_mispredict),
    .o_count (mispredict_count)
  );

endmodule
